// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, syncs, blank,
// line/frame strobes and a free-running frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        clk_en,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Counters are 10 bits wide, so neither total may exceed 1024.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
            $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024");
        end
    endgenerate

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic        h_end;
    logic        v_end;
    logic [9:0]  x_nxt;
    logic [9:0]  y_nxt;
    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic        hs_act;
    logic        vs_act;
    logic        vis_nxt;

    // Next raster position and the levels that describe it, so that the
    // registered levels always match the registered counters.
    always_comb begin
        h_end   = ({1'b0, DrawX} == H_LAST);
        v_end   = ({1'b0, DrawY} == V_LAST);
        x_nxt   = h_end ? 10'd0 : DrawX + 10'd1;
        y_nxt   = DrawY;
        if (h_end) begin
            y_nxt = v_end ? 10'd0 : DrawY + 10'd1;
        end
        x_ext   = {1'b0, x_nxt};
        y_ext   = {1'b0, y_nxt};
        hs_act  = (x_ext >= HS_BEG) && (x_ext < HS_END);
        vs_act  = (y_ext >= VS_BEG) && (y_ext < VS_END);
        vis_nxt = (x_ext < H_VIS) && (y_ext < V_VIS);
    end

    // Raster state: advance on clk_en, hold otherwise; strobes last one
    // enabled cycle and are cleared whenever the raster is not advancing.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            blank       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
        end else if (clk_en) begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            hs          <= hs_act ? HS_POL : ~HS_POL;
            vs          <= vs_act ? VS_POL : ~VS_POL;
            blank       <= vis_nxt;
            line_start  <= h_end;
            frame_start <= h_end && v_end;
            if (h_end && v_end) begin
                frame_count <= frame_count + 16'd1;
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance for line
// timing and a reduced-timing instance for frame-level behaviour.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b1;

    logic [9:0]  x, y, xs, ys;
    logic        hs, vs, blank, ls, fs;
    logic        hs_s, vs_s, blank_s, ls_s, fs_s;
    logic [15:0] fc, fc_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #20 clk = ~clk;

    vga_timing_gen dut (
        .vga_clk(clk), .reset(reset), .clk_en(clk_en),
        .DrawX(x), .DrawY(y), .hs(hs), .vs(vs), .blank(blank),
        .line_start(ls), .frame_start(fs), .frame_count(fc)
    );

    // Small raster: H 8+2+3+3 = 16, V 6+1+2+1 = 10, 160 clks/frame.
    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .vga_clk(clk), .reset(reset), .clk_en(clk_en),
        .DrawX(xs), .DrawY(ys), .hs(hs_s), .vs(vs_s), .blank(blank_s),
        .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int blank_fall, hs_first, hs_last, hs_cnt, ls_cnt, vs_cnt;
    int vs_first, vs_last, fs_cnt, px, py, ex, err, ls_at;

    initial begin
        // 1. reset held 3 clocks
        repeat (3) tick();
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_blank", blank, 1);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_ls", ls, 0);
        check("rst_fs", fs, 0);
        check("rst_fc", fc, 0);
        reset = 1'b0;
        tick();
        check("rel_x", x, 1);
        check("rel_y", y, 0);
        check("rel_ls", ls, 0);

        // 2. one full line on the full-size raster
        blank_fall = -1; hs_first = -1; hs_last = -1;
        hs_cnt = 0; ls_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 799; i++) begin
            tick();
            if (!blank && blank_fall < 0) blank_fall = int'(x);
            if (!hs) begin
                if (hs_first < 0) hs_first = int'(x);
                hs_last = int'(x);
                hs_cnt++;
            end
            if (!vs) vs_cnt++;
            if (ls) ls_cnt++;
        end
        check("line_wrap_x", x, 0);
        check("line_wrap_y", y, 1);
        check("line_ls", ls, 1);
        check("line_ls_cnt", ls_cnt, 1);
        check("blank_fall_x", blank_fall, 640);
        check("hs_first", hs_first, 656);
        check("hs_last", hs_last, 751);
        check("hs_cnt", hs_cnt, 96);
        check("line0_vs_low", vs_cnt, 0);
        tick();
        check("line_ls_drop", ls, 0);
        check("line1_x", x, 1);

        // 3. one full frame on the small raster
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vs_cnt = 0; vs_first = -1; vs_last = -1; fs_cnt = 0;
        px = -1; py = -1;
        for (int i = 1; i <= 160; i++) begin
            tick();
            if (i == 159) begin
                px = int'(xs);
                py = int'(ys);
            end
            if (!vs_s) begin
                if (vs_first < 0) vs_first = int'(ys);
                vs_last = int'(ys);
                vs_cnt++;
            end
            if (fs_s) fs_cnt++;
        end
        check("pre_wrap_x", px, 15);
        check("pre_wrap_y", py, 9);
        check("frame_x", xs, 0);
        check("frame_y", ys, 0);
        check("frame_fs", fs_s, 1);
        check("frame_ls", ls_s, 1);
        check("frame_fc", fc_s, 1);
        check("frame_fs_cnt", fs_cnt, 1);
        check("vs_cnt", vs_cnt, 32);
        check("vs_first", vs_first, 7);
        check("vs_last", vs_last, 8);
        tick();
        check("frame_fs_drop", fs_s, 0);
        check("frame_ls_drop", ls_s, 0);

        // 4. clk_en alternating 1,0 on the full-size raster
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ex = 0; err = 0; ls_cnt = 0; ls_at = -1;
        for (int i = 0; i < 1600; i++) begin
            clk_en = (i % 2 == 0);
            tick();
            if (clk_en) ex = (ex == 799) ? 0 : ex + 1;
            if (int'(x) != ex) err++;
            if (ls) begin
                ls_cnt++;
                ls_at = i;
            end
        end
        clk_en = 1'b1;
        check("en_track_err", err, 0);
        check("en_ls_cnt", ls_cnt, 1);
        check("en_ls_at", ls_at, 1598);
        check("en_y", y, 1);

        // 5. reset mid-frame on the small raster
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (853) tick();
        check("mid_fc", fc_s, 5);
        check("mid_x", xs, 5);
        check("mid_y", ys, 3);
        reset = 1'b1;
        tick();
        check("mrst_x", xs, 0);
        check("mrst_y", ys, 0);
        check("mrst_fc", fc_s, 0);
        check("mrst_fs", fs_s, 0);
        check("mrst_ls", ls_s, 0);
        check("mrst_blank", blank_s, 1);
        reset = 1'b0;

        // 6. frame counter wrap 65535 -> 0
        force dut_s.frame_count = 16'hFFFF;
        #1;
        release dut_s.frame_count;
        check("fc_preset", fc_s, 65535);
        repeat (159) tick();
        check("fc_hold", fc_s, 65535);
        tick();
        check("fc_wrap", fc_s, 0);
        check("fc_wrap_fs", fs_s, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
